// File: rtl/irq_pc_sched.sv
// irq_pc_sched: PC-source select and interrupt-entry sequencer beside rf_stage; iack one cycle after irq (two behind a transfer); pause freezes state and forces PC_KEP.
// Optional build macro IRQ_PC_SCHED_CPI_CNT_EN adds free-running clock and retired-instruction counters.
module irq_pc_sched #(
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        irq_i,
  input  logic        pause,
  input  logic [2:0]  pc_gen_ctl,
  output logic [3:0]  pc_src_o,
  output logic        iack_o,
  output logic        id2ra_ctl_clr_o,
  output logic        id2ra_ctl_cls_o,
  output logic        ra2ex_ctl_clr_o,
  output logic        irq_busy_o
`ifdef IRQ_PC_SCHED_CPI_CNT_EN
  ,
  output logic [63:0] clk_no_o,
  output logic [63:0] ins_no_o
`endif
);

  localparam logic [2:0] PC_J   = 3'd1;
  localparam logic [2:0] PC_JR  = 3'd2;
  localparam logic [2:0] PC_BC  = 3'd3;
  localparam logic [2:0] PC_RET = 3'd4;

  localparam logic [3:0] PC_IGN = 4'd0;
  localparam logic [3:0] PC_KEP = 4'd1;
  localparam logic [3:0] PC_IRQ = 4'd2;

  localparam logic       HAS_FLUSH = (FLUSH_CYC > 1);
  localparam logic [3:0] CNT_LOAD  = 4'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    VECTOR    = 3'd2,
    FLUSH     = 3'd3,
    IN_ISR    = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       pend;
  logic       xfer;
  logic       is_ret;

  assign xfer   = (pc_gen_ctl == PC_J) || (pc_gen_ctl == PC_JR) ||
                  (pc_gen_ctl == PC_BC) || (pc_gen_ctl == PC_RET);
  assign is_ret = (pc_gen_ctl == PC_RET);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
      pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Requests seen while paused are remembered so a short pulse is not lost.
          pend <= pend | irq_i;
          if (!pause && (irq_i || pend))
            state <= xfer ? WAIT_SLOT : VECTOR;
        end
        WAIT_SLOT: if (!pause) state <= VECTOR;
        VECTOR: if (!pause) begin
          pend  <= 1'b0;
          cnt   <= CNT_LOAD;
          state <= HAS_FLUSH ? FLUSH : IN_ISR;
        end
        FLUSH: if (!pause) begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= IN_ISR;
        end
        IN_ISR: if (!pause && is_ret) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pc_src_o        = PC_IGN;
    iack_o          = 1'b0;
    id2ra_ctl_clr_o = 1'b0;
    id2ra_ctl_cls_o = 1'b0;
    ra2ex_ctl_clr_o = 1'b0;
    irq_busy_o      = 1'b0;
    if (!rst_i) begin
      irq_busy_o = (state == VECTOR) || (state == FLUSH) || (state == IN_ISR);
      if (pause) begin
        pc_src_o = PC_KEP;
      end else begin
        case (state)
          VECTOR: begin
            pc_src_o        = PC_IRQ;
            iack_o          = 1'b1;
            id2ra_ctl_clr_o = 1'b1;
            ra2ex_ctl_clr_o = 1'b1;
          end
          FLUSH:   id2ra_ctl_clr_o = 1'b1;
          IN_ISR:  id2ra_ctl_cls_o = is_ret;
          default: pc_src_o = PC_IGN;
        endcase
      end
    end
  end

`ifdef IRQ_PC_SCHED_CPI_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_i) begin
      clk_no_o <= 64'd0;
      ins_no_o <= 64'd0;
    end else begin
      clk_no_o <= clk_no_o + 64'd1;
      if (!pause && !id2ra_ctl_clr_o)
        ins_no_o <= ins_no_o + 64'd1;
    end
  end
`endif

endmodule

// File: doc/irq_pc_sched.md
Name: irq_pc_sched

Overview:
- Pipeline sequencer for the mips789 register-fetch stage.
- Each cycle it selects the PC source for the rf_stage PC generator: normal, keep (stall) or interrupt vector.
- It also sequences interrupt entry: it waits out any branch delay slot, vectors, acknowledges, flushes ID/RA and EX control, and masks further interrupts until the handler returns.
- It sits beside rf_stage and drives its 4-bit PC-source select plus the id2ra/ra2ex clear controls.

Parameters:
FLUSH_CYC, 2, total cycles id2ra_ctl_clr_o is held on interrupt entry, counting the VECTOR cycle (legal 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_i  input  1  reset, synchronous, active-high
irq_i  input  1  external interrupt request, level, sampled each clk
pause  input  1  global pipeline stall
pc_gen_ctl  input  3  PC-generation command of the instruction in RA (`PC_J/`PC_JR/`PC_BC/`PC_RET/other from mips789_defs.v)
pc_src_o  output  4  PC source select: `PC_IGN, `PC_KEP or `PC_IRQ
iack_o  output  1  interrupt acknowledge, one-cycle pulse
id2ra_ctl_clr_o  output  1  clear ID->RA control register
id2ra_ctl_cls_o  output  1  squash ID->RA control on handler return
ra2ex_ctl_clr_o  output  1  clear RA->EX control register
irq_busy_o  output  1  high from VECTOR through IN_ISR (interrupts masked)

Behaviour:
- Reset (rst_i high at an edge): state=IDLE, flush counter=0, pending=0. During and after the reset cycle: pc_src_o=`PC_IGN and all other outputs 0. Reset mid-sequence aborts it; no iack_o is issued.
- Outputs are decoded from the registered state, with a combinational override from pause.
- pause=1 in any state:
  - pc_src_o=`PC_KEP; iack_o, clears and cls forced 0.
  - State, counter and pending are frozen. Exception: pending may still be set in IDLE.
- Transfer test: "xfer" = pc_gen_ctl in {`PC_J, `PC_JR, `PC_BC, `PC_RET}.
- IDLE: pc_src_o=`PC_IGN. pending <= pending | irq_i.
  - (irq_i|pending) & !pause & xfer -> WAIT_SLOT.
  - (irq_i|pending) & !pause & !xfer -> VECTOR.
- WAIT_SLOT: pc_src_o=`PC_IGN (delay slot proceeds). After one non-paused cycle -> VECTOR.
- VECTOR (1 non-paused cycle):
  - pc_src_o=`PC_IRQ; iack_o=1; id2ra_ctl_clr_o=1; ra2ex_ctl_clr_o=1.
  - pending cleared; counter loaded with FLUSH_CYC-1.
  - Next state: FLUSH if FLUSH_CYC>1, else IN_ISR.
- FLUSH: pc_src_o=`PC_IGN; id2ra_ctl_clr_o=1. Counter decrements on each non-paused cycle; at 1 -> IN_ISR.
- IN_ISR: pc_src_o=`PC_IGN; irq_i ignored (no pending set). pc_gen_ctl==`PC_RET & !pause -> IDLE, with id2ra_ctl_cls_o=1 for that cycle.
- irq_busy_o=1 in VECTOR, FLUSH and IN_ISR.
- Latency: irq_i high at edge n (IDLE, no pause, !xfer) -> iack_o high in cycle n+1. With xfer -> iack_o in n+2.
- Simultaneous events:
  - `PC_RET in IN_ISR with irq_i=1: return wins; irq_i is re-sampled in IDLE next cycle, so a new entry occurs (back-to-back interrupts allowed).
  - rst_i overrides everything.
- iack_o is never asserted twice without an intervening `PC_RET or reset.

Optional Feature:
- Macro: IRQ_PC_SCHED_CPI_CNT_EN.
- Defined: adds outputs clk_no_o[63:0] and ins_no_o[63:0], both reset to 0.
  - clk_no_o increments every non-reset cycle.
  - ins_no_o increments on cycles with pause=0 and id2ra_ctl_clr_o=0 (retired-instruction proxy).
  - Both wrap modulo 2^64.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: rst_i=1 for 2 cycles with irq_i=1 -> pc_src_o=`PC_IGN, iack_o=0, irq_busy_o=0; after release, iack_o at the 2nd edge.
- Plain IRQ, FLUSH_CYC=2: irq_i=1 at edge 10, pc_gen_ctl=0 -> cycle 11: pc_src_o=`PC_IRQ, iack_o=1, both clears=1; cycle 12: id2ra_ctl_clr_o=1 only; cycle 13: IN_ISR, busy=1.
- Delay slot: irq_i with pc_gen_ctl=`PC_BC -> one WAIT_SLOT cycle with pc_src_o=`PC_IGN, then `PC_IRQ, iack_o=1.
- Pause during VECTOR for 3 cycles -> pc_src_o=`PC_KEP and iack_o=0 for those 3 cycles; then exactly one cycle of `PC_IRQ with iack_o=1.
- Masking/return: irq_i held high in IN_ISR for 20 cycles -> no iack_o. Then `PC_RET -> id2ra_ctl_cls_o=1 for 1 cycle; next cycle IDLE; following cycle VECTOR with a second iack_o.
- With IRQ_PC_SCHED_CPI_CNT_EN: 100 cycles with 10 paused and 2 cleared -> clk_no_o=100, ins_no_o=88.
